// File: rtl/sign_restore.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sign_restore                                                  |
// | Function : serial two's-complement rebuild of magnitude + sign, one      |
// |            SLICE-bit carry-lookahead slice per cycle, LSB first.         |
// | Option   : SIGN_RESTORE_SATURATE_EN clamps the result on overflow.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sign_restore #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] magnitude,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef SIGN_RESTORE_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] mag_q;
  logic             sign_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] value_q;
  logic             ovf_q;

  logic             accept;
  logic             last_slice;
  logic             ovf_capture;
  logic [31:0]      slice_lsb;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_sum;
  logic [SLICE:0]   slice_c;
  logic [WIDTH-1:0] sat_value;

  assign accept     = in_valid & in_ready;
  assign last_slice = (state_q == S_CALC) && (cnt_q == LAST_SLICE);

  // mag > 2^(WIDTH-1) when negating: MSB set and any lower bit set
  assign ovf_capture = sign ? (magnitude[WIDTH-1] & (|magnitude[WIDTH-2:0]))
                            : magnitude[WIDTH-1];

  assign sat_value = sign_q ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};

  // ---------------------------------------------------------------------
  // Carry-lookahead slice: operand is (mag ^ sign) plus incoming carry,
  // so every internal carry is carry_in AND all lower operand bits.
  // ---------------------------------------------------------------------
  assign slice_lsb = 32'(cnt_q) * 32'(SLICE);
  assign slice_a   = mag_q[slice_lsb +: SLICE] ^ {SLICE{sign_q}};
  assign slice_c[0] = carry_q;

  for (genvar i = 1; i <= SLICE; i++) begin : g_cla
    assign slice_c[i] = carry_q & (&slice_a[i-1:0]);
  end

  assign slice_sum = slice_a ^ slice_c[SLICE-1:0];

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)     state_d = S_CALC;
      S_CALC:  if (last_slice) state_d = S_DONE;
      S_DONE:  if (out_ready)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; in_ready is masked while reset is asserted
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = ~reset;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_q   <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      mag_q   <= magnitude;
      sign_q  <= sign;
      carry_q <= sign;
      cnt_q   <= '0;
      ovf_q   <= ovf_capture;
    end else if (state_q == S_CALC) begin
      carry_q <= slice_c[SLICE];
      cnt_q   <= last_slice ? '0 : cnt_q + 1'b1;
      if (SAT_EN && last_slice && ovf_q) begin
        value_q <= sat_value;
      end else begin
        value_q[slice_lsb +: SLICE] <= slice_sum;
      end
    end
  end

  assign value    = value_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sign_restore.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sign_restore                                               |
// | Function : self-checking bench for sign_restore against an arithmetic    |
// |            reference model (honours SIGN_RESTORE_SATURATE_EN).           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_sign_restore;

  localparam int W   = 16;
  localparam int S   = 4;
  localparam int NSL = W / S;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] magnitude;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] value;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;

  sign_restore #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .magnitude (magnitude),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .value     (value),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: signed integer arithmetic, result taken modulo 2^W
  function automatic logic [W:0] model(input logic [W-1:0] m, input logic s);
    longint half = longint'(1) << (W - 1);
    longint mi   = longint'(m);
    longint r;
    logic   o;
    if (s) begin
      r = -mi;
      o = (mi > half);
    end else begin
      r = mi;
      o = (mi >= half);
    end
`ifdef SIGN_RESTORE_SATURATE_EN
    if (o) r = s ? -half : half - 1;
`endif
    return {o, r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick_mag();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return {1'b1, {(W-2){1'b0}}, 1'b1};
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Drive one operand with out_ready=1; returns result and cycles to out_valid
  task automatic run_op(input logic [W-1:0] m, input logic s,
                        output logic [W-1:0] v, output logic o, output int lat);
    int w = 0;
    @(negedge clk);
    magnitude = m; sign = s; in_valid = 1'b1; out_ready = 1'b1;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; magnitude = W'($urandom); sign = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    v = value;
    o = overflow;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; magnitude = 16'h1234; sign = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (value !== 16'h0000) $display("FAIL reset_value: got %h expected 0000", value); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_directed();
    logic [15:0] d_mag  [10] = '{16'h0005, 16'h1234, 16'h0000, 16'h8000, 16'h8001,
                                 16'h9000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h0000};
    logic        d_sign [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] d_wrap [10] = '{16'hFFFB, 16'h1234, 16'h0000, 16'h8000, 16'h7FFF,
                                 16'h9000, 16'h7FFF, 16'h8001, 16'h0001, 16'h0000};
    logic [15:0] d_sat  [10] = '{16'hFFFB, 16'h1234, 16'h0000, 16'h8000, 16'h8000,
                                 16'h7FFF, 16'h7FFF, 16'h8001, 16'h8000, 16'h0000};
    logic        d_ovf  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] v;
    logic         o;
    logic [15:0]  ev;
    int           lat;
    for (int i = 0; i < 10; i++) begin
`ifdef SIGN_RESTORE_SATURATE_EN
      ev = d_sat[i];
`else
      ev = d_wrap[i];
`endif
      run_op(d_mag[i], d_sign[i], v, o, lat);
      n_checks++; if (v !== ev) $display("FAIL dir_value[%0d]: got %h expected %h", i, v, ev); else n_pass++;
      n_checks++; if (o !== d_ovf[i]) $display("FAIL dir_overflow[%0d]: got %b expected %b", i, o, d_ovf[i]); else n_pass++;
      n_checks++; if (lat !== NSL) $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, NSL); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL dir_idle[%0d]: got in_ready %b expected 1", i, in_ready); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp = model(16'h4321, 1'b1);
    int w = 0;
    @(negedge clk);
    magnitude = 16'h4321; sign = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_timeout: got out_valid %b expected 1", out_valid); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; magnitude = W'($urandom); sign = 1'($urandom);
      #1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); else n_pass++;
      n_checks++; if (value !== exp[W-1:0]) $display("FAIL bp_value[%0d]: got %h expected %h", i, value, exp[W-1:0]); else n_pass++;
      n_checks++; if (overflow !== exp[W]) $display("FAIL bp_overflow[%0d]: got %b expected %b", i, overflow, exp[W]); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ignored_op: got in_ready %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_calc();
    logic [W-1:0] v;
    logic         o;
    int           lat;
    @(negedge clk);
    magnitude = 16'h1357; sign = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_calc_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (value !== 16'h0000) $display("FAIL rst_calc_value: got %h expected 0000", value); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_calc_in_ready: got %b expected 0", in_ready); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_calc_no_partial[%0d]: got %b expected 0", i, out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_calc_idle[%0d]: got %b expected 1", i, in_ready); else n_pass++;
    end
    run_op(16'h00FF, 1'b1, v, o, lat);
    n_checks++; if (v !== 16'hFF01) $display("FAIL rst_follow_value: got %h expected FF01", v); else n_pass++;
    n_checks++; if (o !== 1'b0) $display("FAIL rst_follow_overflow: got %b expected 0", o); else n_pass++;
  endtask

  task automatic test_reset_in_done();
    int w = 0;
    @(negedge clk);
    magnitude = 16'h0042; sign = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_done_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (value !== 16'h0000) $display("FAIL rst_done_value: got %h expected 0000", value); else n_pass++;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [W:0] q[$];
    logic [W:0] exp;
    int  n_ops = 150;
    int  acc = 0, got = 0, cyc = 0;
    logic took = 1'b0;
    in_valid = 1'b0;
    while (got < n_ops && cyc < 20000) begin
      @(negedge clk);
      if (!in_valid || took) begin
        in_valid  = (acc < n_ops) && ($urandom_range(0, 3) != 0);
        magnitude = pick_mag();
        sign      = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      took = in_valid && in_ready;
      if (took) begin
        q.push_back(model(magnitude, sign));
        acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL rnd_spurious: got out_valid 1 with no operand outstanding, expected 0");
        end else begin
          exp = q.pop_front();
          n_checks++; if (value !== exp[W-1:0]) $display("FAIL rnd_value[%0d]: got %h expected %h", got, value, exp[W-1:0]); else n_pass++;
          n_checks++; if (overflow !== exp[W]) $display("FAIL rnd_overflow[%0d]: got %b expected %b", got, overflow, exp[W]); else n_pass++;
        end
        got++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (got !== n_ops) $display("FAIL rnd_count: got %0d results expected %0d", got, n_ops); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    logic [W:0] exp;
    int  acc_cyc[$];
    int  n_ops = 6;
    int  acc = 0, got = 0, cyc = 0;
    logic took = 1'b1;
    while (got < n_ops && cyc < 500) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (took) begin
        in_valid  = (acc < n_ops);
        magnitude = pick_mag();
        sign      = 1'($urandom);
      end
      #1;
      took = in_valid && in_ready;
      if (took) begin
        q.push_back(model(magnitude, sign));
        acc_cyc.push_back(cyc);
        acc++;
      end
      if (out_valid && q.size() != 0) begin
        exp = q.pop_front();
        n_checks++; if (value !== exp[W-1:0]) $display("FAIL b2b_value[%0d]: got %h expected %h", got, value, exp[W-1:0]); else n_pass++;
        n_checks++; if (overflow !== exp[W]) $display("FAIL b2b_overflow[%0d]: got %b expected %b", got, overflow, exp[W]); else n_pass++;
        got++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (acc_cyc.size() !== n_ops) $display("FAIL b2b_count: got %0d accepts expected %0d", acc_cyc.size(), n_ops); else n_pass++;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== NSL + 2)
        $display("FAIL b2b_spacing[%0d]: got %0d cycles expected %0d", i, acc_cyc[i] - acc_cyc[i-1], NSL + 2);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; magnitude = '0; sign = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_calc();
    test_reset_in_done();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
